spi_fir_sequencer: RTL and testbench
====================================

// Module: spi_fir_sequencer
// PURPOSE
//  Sits between SPI_slave and the FIR datapath. Assembles received SPI bytes into
//  samples and buffers them in a FIFO. Feeds the FIR through a valid/ready handshake.
//  Captures FIR results and serves them back as MISO bytes.
// PARAMETERS
//  SAMPLE_BYTES  2   bytes per input sample, MSB first; sample width SW = 8*SAMPLE_BYTES
//  FIFO_DEPTH    8   input sample FIFO entries; power of two, >= 2
//  OUT_BYTES     2   bytes per FIR result; result width OW = 8*OUT_BYTES
// PORTS
//  clk            in   1        system clock, all logic on rising edge
//  rst            in   1        asynchronous, active-high reset
//  rx_valid       in   1        one-cycle strobe: rx_byte holds a complete SPI byte
//  rx_byte        in   8        received SPI byte
//  ssel_active    in   1        synchronised chip-select, high while a message is in progress
//  fir_in_valid   out  1        head sample available to the FIR
//  fir_in_ready   in   1        FIR accepts the sample this cycle
//  fir_in_data    out  SW       head-of-FIFO sample
//  fir_out_valid  in   1        one-cycle strobe: fir_out_data is a new result
//  fir_out_data   in   OW       FIR result
//  tx_byte        out  8        byte the SPI slave loads for its next MISO shift
//  fifo_level     out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  overflow       out  1        sticky: a sample was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty. Assembler in IDLE with byte index 0.
//   Result and pending registers cleared. Sticky flag cleared.
//  Assembler FSM:
//   - IDLE -> COLLECT on rx_valid while ssel_active; first byte goes to bits [SW-1:SW-8].
//   - COLLECT: each rx_valid shifts the next byte in and increments the byte index.
//   - On byte SAMPLE_BYTES the full sample is pushed and the FSM returns to IDLE
//     with index 0.
//   - ssel_active low in COLLECT discards the partial sample and returns to IDLE.
//     No push occurs.
//   - rx_valid while ssel_active is low is ignored.
//  FIFO push rules:
//   - Push takes effect at the edge ending the cycle of the final rx_valid (cycle N).
//     fir_in_valid is high in cycle N+1 if the FIFO was empty. Latency is 1 cycle.
//   - Full, no pop in the same cycle: the sample is dropped, overflow is set, and
//     fifo_level is unchanged.
//   - Full, with a pop in the same cycle: the push is accepted and the level stays
//     FIFO_DEPTH.
//   - Empty, with a push in the same cycle: there is no fall-through. Data appears
//     next cycle.
//  FIR handshake:
//   - fir_in_valid = (level != 0).
//   - Transfer occurs when fir_in_valid && fir_in_ready. The head pops on that edge.
//   - While valid && !ready, fir_in_data and fir_in_valid hold stable.
//   - fir_in_valid never drops without a transfer, except on reset.
//  Pointers: wrap modulo FIFO_DEPTH. The level counter saturates at neither bound;
//   the rules above keep it within range.
//  Result path:
//   - fir_out_valid loads fir_out_data into a pending register. The latest result wins.
//   - On the rising edge of ssel_active (start of message), pending is copied into the
//     tx register and the tx index resets to 0.
//   - tx_byte = tx register byte [index], MSB byte first.
//   - Each accepted rx_valid advances the index, wrapping after OUT_BYTES.
//   - A result arriving mid-message does not alter the current tx register (no tearing).
//  Simultaneous fir_out_valid and start-of-message: the new result is copied to the
//   tx register.
//  Overflow: stays set until rst. No other clear path.
//  Reset mid-operation: FIFO contents, the partial sample and the pending result are
//   all lost. All outputs return to 0 asynchronously.
// STRUCTURE
//  Shared package spi_fir_pkg:
//   - constants SAMPLE_BYTES, OUT_BYTES, SW, OW
//   - assembler state encoding {IDLE, COLLECT}
//  Sub-module sync_fifo (WIDTH=SW, DEPTH=FIFO_DEPTH): registered output, level,
//   full/empty, push-when-full-with-pop allowed.
//  Assembler FSM, handshake glue and tx register live in this module.
// TESTING
//  1. Reset, then one message 0x12,0x34 with fir_in_ready=1 -> fir_in_data=0x1234
//     for exactly one cycle, one cycle after the 2nd rx_valid; fifo_level 1->0.
//  2. Message of 0xAB, then ssel_active drops -> no push, fifo_level=0, next message
//     0x00,0x01 yields sample 0x0001.
//  3. fir_in_ready=0, send 9 samples -> fifo_level=8, overflow=1, head sample = 1st
//     sent; data held stable throughout.
//  4. FIFO full, push and pop in the same cycle -> level stays 8, no overflow, new
//     sample appears as the last entry.
//  5. fir_out_valid with 0xBEEF, start message, 3 rx bytes -> tx_byte 0xBE, 0xEF,
//     0xBE; result 0x1111 arriving mid-message is first seen next message.
//  6. Assert rst mid-COLLECT with FIFO at 3 -> outputs 0 immediately, fifo_level=0,
//     overflow=0.

Source files
------------

// File: rtl/spi_fir_pkg.sv
// Shared constants and assembler state encoding for the SPI <-> FIR sequencer.
package spi_fir_pkg;
    localparam int SAMPLE_BYTES = 2;
    localparam int OUT_BYTES    = 2;
    localparam int SW           = 8 * SAMPLE_BYTES;
    localparam int OW           = 8 * OUT_BYTES;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (level == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= AW'(wr_ptr + 1'b1);
            end
            if (do_pop) rd_ptr <= AW'(rd_ptr + 1'b1);
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/spi_fir_sequencer.sv
// Assembles SPI bytes into samples for the FIR via a FIFO and serves FIR
// results back to the SPI slave one byte at a time.
module spi_fir_sequencer
    import spi_fir_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_byte,
    input  logic                         ssel_active,
    output logic                         fir_in_valid,
    input  logic                         fir_in_ready,
    output logic [SW-1:0]                fir_in_data,
    input  logic                         fir_out_valid,
    input  logic [OW-1:0]                fir_out_data,
    output logic [7:0]                   tx_byte,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow
);
    localparam int IW = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam int TW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    logic [0:0]     state;
    logic [IW-1:0]  byte_idx;
    logic [SW-1:0]  shift;
    logic [SW+7:0]  shift_ext;
    logic           accept, last_byte, push, pop, full, empty;

    // Bytes enter at the LSB; after SAMPLE_BYTES of them the first is at the MSB.
    assign shift_ext = {shift, rx_byte};
    assign accept    = rx_valid && ssel_active;
    assign last_byte = (byte_idx == IW'(SAMPLE_BYTES - 1));
    assign push      = accept && last_byte;
    assign pop       = fir_in_valid && fir_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            byte_idx <= '0;
            shift    <= '0;
        end else if (!ssel_active) begin
            state    <= ST_IDLE;
            byte_idx <= '0;
        end else if (accept) begin
            shift <= shift_ext[SW-1:0];
            if (last_byte) begin
                state    <= ST_IDLE;
                byte_idx <= '0;
            end else begin
                state    <= ST_COLLECT;
                byte_idx <= IW'(byte_idx + 1'b1);
            end
        end
    end

    sync_fifo #(.WIDTH(SW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift_ext[SW-1:0]),
        .pop       (pop),
        .head      (fir_in_data),
        .level     (fifo_level),
        .full      (full),
        .empty     (empty)
    );

    assign fir_in_valid = !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          overflow <= 1'b0;
        else if (push && full && !pop)    overflow <= 1'b1;
    end

    logic [OW-1:0] pending, tx_reg, tx_sh;
    logic [TW-1:0] tx_idx;
    logic          ssel_d, msg_start;

    assign msg_start = ssel_active && !ssel_d;

    // tx_reg only reloads at message start so a mid-message result cannot tear the reply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssel_d  <= 1'b0;
            pending <= '0;
            tx_reg  <= '0;
            tx_idx  <= '0;
        end else begin
            ssel_d <= ssel_active;
            if (fir_out_valid) pending <= fir_out_data;
            if (msg_start) begin
                tx_reg <= fir_out_valid ? fir_out_data : pending;
                tx_idx <= '0;
            end else if (accept) begin
                tx_idx <= (tx_idx == TW'(OUT_BYTES - 1)) ? '0 : TW'(tx_idx + 1'b1);
            end
        end
    end

    assign tx_sh   = tx_reg << (8 * tx_idx);
    assign tx_byte = tx_sh[OW-1 -: 8];
endmodule

// File: tb/tb_spi_fir_sequencer.sv
// Randomized plus directed bench for spi_fir_sequencer against a queue-based model.
module tb_spi_fir_sequencer;
    import spi_fir_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 0, rst = 1;
    logic        rx_valid = 0, ssel_active = 0, fir_in_ready = 0, fir_out_valid = 0;
    logic [7:0]  rx_byte = 0;
    logic [OW-1:0] fir_out_data = 0;
    logic        fir_in_valid, overflow;
    logic [SW-1:0] fir_in_data;
    logic [7:0]  tx_byte;
    logic [$clog2(DEPTH):0] fifo_level;

    int checks = 0, failures = 0;

    spi_fir_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .ssel_active(ssel_active), .fir_in_valid(fir_in_valid),
        .fir_in_ready(fir_in_ready), .fir_in_data(fir_in_data),
        .fir_out_valid(fir_out_valid), .fir_out_data(fir_out_data),
        .tx_byte(tx_byte), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [SW-1:0] mq[$];
    logic [7:0]    parts[$];
    logic [OW-1:0] m_pending, m_tx;
    int            m_txidx;
    bit            m_ovf, m_ssel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete(); parts.delete();
        m_pending = 0; m_tx = 0; m_txidx = 0; m_ovf = 0; m_ssel = 0;
    endfunction

    function automatic logic [7:0] exp_tx();
        logic [OW-1:0] v;
        v = m_tx >> (8 * (OUT_BYTES - 1 - m_txidx));
        return v[7:0];
    endfunction

    task automatic check_all();
        chk("valid", 32'(fir_in_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("data", 32'(fir_in_data), 32'(mq[0]));
        chk("level", 32'(fifo_level), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("tx_byte", 32'(tx_byte), 32'(exp_tx()));
    endtask

    // Called at a negedge: apply inputs, advance the model, clock, check.
    task automatic step(input bit rxv, input logic [7:0] b, input bit ss, input bit rdy,
                        input bit fov, input logic [OW-1:0] fod);
        bit pop, pushv;
        int sz;
        logic [SW-1:0] pd;
        rx_valid = rxv; rx_byte = b; ssel_active = ss; fir_in_ready = rdy;
        fir_out_valid = fov; fir_out_data = fod;
        pop = (mq.size() != 0) && rdy;
        pushv = 0; pd = 0;
        if (!ss) parts.delete();
        else if (rxv) begin
            parts.push_back(b);
            if (parts.size() == SAMPLE_BYTES) begin
                foreach (parts[i]) pd = (pd << 8) | SW'(parts[i]);
                pushv = 1;
                parts.delete();
            end
        end
        sz = mq.size();
        if (pop) void'(mq.pop_front());
        if (pushv) begin
            if (sz < DEPTH || pop) mq.push_back(pd);
            else m_ovf = 1;
        end
        if (ss && !m_ssel) begin
            m_tx = fov ? fod : m_pending;
            m_txidx = 0;
        end else if (rxv && ss) m_txidx = (m_txidx + 1) % OUT_BYTES;
        if (fov) m_pending = fod;
        m_ssel = ss;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1; rx_valid = 0; ssel_active = 0; fir_in_ready = 0; fir_out_valid = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_all();
    endtask

    task automatic send_sample(input logic [SW-1:0] s, input bit rdy);
        logic [SW-1:0] v;
        v = s;
        for (int k = 0; k < SAMPLE_BYTES; k++)
            step(1, v[SW-1-8*k -: 8], 1, rdy, 0, 0);
    endtask

    initial begin
        bit ss, rdy;
        int rdy_pct;
        model_reset();
        @(negedge clk);
        chk("rst_valid", 32'(fir_in_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_data", 32'(fir_in_data), 0);
        chk("rst_tx", 32'(tx_byte), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 0;
        @(negedge clk);
        check_all();

        // 1: single sample, one-cycle latency, popped immediately
        step(0, 0, 1, 1, 0, 0);
        step(1, 8'h12, 1, 1, 0, 0);
        step(1, 8'h34, 1, 1, 0, 0);
        chk("t1_data", 32'(fir_in_data), 32'h1234);
        chk("t1_lvl1", 32'(fifo_level), 1);
        step(0, 0, 1, 1, 0, 0);
        chk("t1_lvl0", 32'(fifo_level), 0);

        // 2: partial sample discarded by chip-select drop
        step(1, 8'hAB, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 8'h77, 0, 1, 0, 0);
        chk("t2_lvl", 32'(fifo_level), 0);
        step(1, 8'h00, 1, 0, 0, 0);
        step(1, 8'h01, 1, 0, 0, 0);
        chk("t2_data", 32'(fir_in_data), 32'h0001);
        step(0, 0, 0, 1, 0, 0);

        // 3: overflow with FIR stalled
        for (int i = 0; i < 9; i++) send_sample(SW'(16'hA000 + i), 0);
        chk("t3_lvl", 32'(fifo_level), DEPTH);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_head", 32'(fir_in_data), 32'hA000);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);

        // 4: full FIFO, push and pop in the same cycle
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_sample(SW'(16'hC000 + i), 0);
        step(1, 8'hD0, 1, 0, 0, 0);
        step(1, 8'h0D, 1, 1, 0, 0);
        chk("t4_lvl", 32'(fifo_level), DEPTH);
        chk("t4_ovf", 32'(overflow), 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0, 0);
        chk("t4_empty", 32'(fifo_level), 0);

        // 5: result readback and no tearing
        step(0, 0, 0, 1, 1, 16'hBEEF);
        step(0, 0, 1, 1, 0, 0);
        chk("t5_b0", 32'(tx_byte), 32'hBE);
        step(1, 8'h01, 1, 1, 0, 0);
        chk("t5_b1", 32'(tx_byte), 32'hEF);
        step(1, 8'h02, 1, 1, 1, 16'h1111);
        chk("t5_b2", 32'(tx_byte), 32'hBE);
        step(1, 8'h03, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        chk("t5_new", 32'(tx_byte), 32'h11);
        // result and start in the same cycle
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 1, 16'h5AC3);
        chk("t5_same", 32'(tx_byte), 32'h5A);
        step(0, 0, 0, 1, 0, 0);

        // 6: asynchronous reset mid-collect with three samples queued
        for (int i = 0; i < 3; i++) send_sample(SW'(16'h3300 + i), 0);
        step(1, 8'h99, 1, 0, 0, 0);
        #2 rst = 1;
        #1;
        chk("t6_valid", 32'(fir_in_valid), 0);
        chk("t6_level", 32'(fifo_level), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_data", 32'(fir_in_data), 0);
        chk("t6_tx", 32'(tx_byte), 0);
        do_reset();

        // random traffic
        ss = 0; rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) rdy_pct = (c / 64) % 3 == 0 ? 10 : ((c / 64) % 3 == 1 ? 50 : 95);
            if ($urandom_range(0, 99) < 6) ss = !ss;
            rdy = ($urandom_range(0, 99) < rdy_pct);
            step($urandom_range(0, 99) < 45, 8'($urandom), ss, rdy,
                 $urandom_range(0, 99) < 8, OW'($urandom));
            if (c == 1500) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
